// File: rtl/servo_track_scheduler.sv
// Solar-tracker sequencer for two servo_driver channels (H azimuth, V elevation).
// Limit sweep on each axis, then sample -> move -> settle loop driven by LDR readings.
module servo_track_scheduler #(
    parameter int DW         = 12,
    parameter int DEADBAND   = 8,
    parameter int STEP_CYC   = 200,
    parameter int SETTLE_CYC = 1000
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          START,
    input  logic          STOP,
    input  logic          VALID,
    input  logic [DW-1:0] LDR_L,
    input  logic [DW-1:0] LDR_R,
    input  logic [DW-1:0] LDR_T,
    input  logic [DW-1:0] LDR_B,
    input  logic          LIMIT_H,
    input  logic          LIMIT_V,
    output logic          BTN0_H,
    output logic          BTN1_H,
    output logic          BTN0_V,
    output logic          BTN1_V,
    output logic          ES_H,
    output logic          ES_V,
    output logic          BUSY,
    output logic [2:0]    STATE
);

    localparam int CMAX = (STEP_CYC > SETTLE_CYC) ? STEP_CYC : SETTLE_CYC;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [CW-1:0] STEP_LAST   = CW'(STEP_CYC - 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);
    localparam logic [CW-1:0] CNT_MAX     = CW'(CMAX);
    localparam logic [CW-1:0] CNT_ONE     = CW'(1);

    localparam logic [DW:0] DB   = (DW + 1)'(DEADBAND);
    localparam logic [DW:0] ZERO = '0;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SWEEP_H = 3'd1;
    localparam logic [2:0] S_SWEEP_V = 3'd2;
    localparam logic [2:0] S_SAMPLE  = 3'd3;
    localparam logic [2:0] S_MOVE_H  = 3'd4;
    localparam logic [2:0] S_MOVE_V  = 3'd5;
    localparam logic [2:0] S_SETTLE  = 3'd6;

    // last_q: 0 = H served last, 1 = V served last
    // dir_q:  1 = ccw (BTN0), 0 = cw (BTN1)
    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          last_q, last_d;
    logic          dir_q, dir_d;
    logic          btn0_h_q, btn0_h_d;
    logic          btn1_h_q, btn1_h_d;
    logic          btn0_v_q, btn0_v_d;
    logic          btn1_v_q, btn1_v_d;
    logic          es_h_q, es_h_d;
    logic          es_v_q, es_v_d;
    logic          busy_q, busy_d;

    logic [DW:0] dh, dv;
    logic [DW:0] mag_h, mag_v;
    logic        req_h, req_v;
    logic        grant_h, grant_v;
    logic        grant_ccw, grant_lim;

    // LDR differences, deadband test and round-robin grant
    always_comb begin
        dh        = {1'b0, LDR_L} - {1'b0, LDR_R};
        dv        = {1'b0, LDR_T} - {1'b0, LDR_B};
        mag_h     = dh[DW] ? (ZERO - dh) : dh;
        mag_v     = dv[DW] ? (ZERO - dv) : dv;
        req_h     = mag_h > DB;
        req_v     = mag_v > DB;
        grant_v   = req_v && (!req_h || !last_q);
        grant_h   = req_h && !grant_v;
        grant_ccw = grant_v ? !dv[DW] : !dh[DW];
        grant_lim = grant_v ? LIMIT_V : LIMIT_H;
    end

    // Next state, served-axis memory, latched direction and step counter
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        dir_d   = dir_q;
        if (STOP) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (START) state_d = S_SWEEP_H;
                end
                S_SWEEP_H: begin
                    if (LIMIT_H) state_d = S_SWEEP_V;
                end
                S_SWEEP_V: begin
                    if (LIMIT_V) state_d = S_SAMPLE;
                end
                S_SAMPLE: begin
                    if (VALID) begin
                        if (!grant_h && !grant_v) begin
                            state_d = S_SETTLE;
                        end else if (grant_ccw && grant_lim) begin
                            state_d = S_SETTLE;
                            last_d  = grant_v;
                        end else begin
                            state_d = grant_v ? S_MOVE_V : S_MOVE_H;
                            dir_d   = grant_ccw;
                        end
                    end
                end
                S_MOVE_H: begin
                    if ((dir_q && LIMIT_H) || (cnt_q == STEP_LAST)) begin
                        state_d = S_SETTLE;
                        last_d  = 1'b0;
                    end
                end
                S_MOVE_V: begin
                    if ((dir_q && LIMIT_V) || (cnt_q == STEP_LAST)) begin
                        state_d = S_SETTLE;
                        last_d  = 1'b1;
                    end
                end
                S_SETTLE: begin
                    if (cnt_q == SETTLE_LAST) state_d = S_SAMPLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // Outputs decoded from the next state so they register alongside it
    always_comb begin
        btn0_h_d = 1'b0;
        btn1_h_d = 1'b0;
        btn0_v_d = 1'b0;
        btn1_v_d = 1'b0;
        es_h_d   = 1'b0;
        es_v_d   = 1'b0;
        busy_d   = (state_d != S_IDLE);
        case (state_d)
            S_SWEEP_H: begin
                es_h_d   = 1'b1;
                btn0_h_d = 1'b1;
            end
            S_SWEEP_V: begin
                es_v_d   = 1'b1;
                btn0_v_d = 1'b1;
            end
            S_MOVE_H: begin
                btn0_h_d = dir_d;
                btn1_h_d = !dir_d;
            end
            S_MOVE_V: begin
                btn0_v_d = dir_d;
                btn1_v_d = !dir_d;
            end
            default: begin
                btn0_h_d = 1'b0;
            end
        endcase
    end

    // State, counter and output registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            last_q   <= 1'b1;
            dir_q    <= 1'b0;
            btn0_h_q <= 1'b0;
            btn1_h_q <= 1'b0;
            btn0_v_q <= 1'b0;
            btn1_v_q <= 1'b0;
            es_h_q   <= 1'b0;
            es_v_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            dir_q    <= dir_d;
            btn0_h_q <= btn0_h_d;
            btn1_h_q <= btn1_h_d;
            btn0_v_q <= btn0_v_d;
            btn1_v_q <= btn1_v_d;
            es_h_q   <= es_h_d;
            es_v_q   <= es_v_d;
            busy_q   <= busy_d;
        end
    end

    assign BTN0_H = btn0_h_q;
    assign BTN1_H = btn1_h_q;
    assign BTN0_V = btn0_v_q;
    assign BTN1_V = btn1_v_q;
    assign ES_H   = es_h_q;
    assign ES_V   = es_v_q;
    assign BUSY   = busy_q;
    assign STATE  = state_q;

endmodule

// File: tb/tb_servo_track_scheduler.sv
// Bench for servo_track_scheduler: directed scenarios plus randomized
// LDR samples checked against a transaction-level tracker model.
module tb_servo_track_scheduler;

    localparam int DW         = 12;
    localparam int DEADBAND   = 8;
    localparam int STEP_CYC   = 200;
    localparam int SETTLE_CYC = 1000;

    logic          CLK = 1'b0;
    logic          RST_N;
    logic          START, STOP, VALID;
    logic [DW-1:0] LDR_L, LDR_R, LDR_T, LDR_B;
    logic          LIMIT_H, LIMIT_V;
    logic          BTN0_H, BTN1_H, BTN0_V, BTN1_V;
    logic          ES_H, ES_V, BUSY;
    logic [2:0]    STATE;

    int total = 0;
    int bad   = 0;
    int last_srv;

    servo_track_scheduler #(
        .DW(DW), .DEADBAND(DEADBAND),
        .STEP_CYC(STEP_CYC), .SETTLE_CYC(SETTLE_CYC)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .START(START), .STOP(STOP),
        .VALID(VALID), .LDR_L(LDR_L), .LDR_R(LDR_R),
        .LDR_T(LDR_T), .LDR_B(LDR_B),
        .LIMIT_H(LIMIT_H), .LIMIT_V(LIMIT_V),
        .BTN0_H(BTN0_H), .BTN1_H(BTN1_H),
        .BTN0_V(BTN0_V), .BTN1_V(BTN1_V),
        .ES_H(ES_H), .ES_V(ES_V), .BUSY(BUSY), .STATE(STATE)
    );

    always #5 CLK = ~CLK;

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    function automatic int btnv();
        return int'({BTN0_H, BTN1_H, BTN0_V, BTN1_V});
    endfunction

    task automatic wait_state(input int s, input string tag);
        int n;
        n = 0;
        while (int'(STATE) != s && n < 5000) begin
            step();
            n++;
        end
        chk(tag, int'(STATE), s);
    endtask

    task automatic do_sweep();
        int bd;
        START = 1'b1;
        step();
        START = 1'b0;
        bd = 0;
        for (int i = 0; i < 50; i++) begin
            if (!(BTN0_H && ES_H) || BTN1_H || int'(STATE) != 1) bd++;
            step();
        end
        chk("sweep_h_hold", bd, 0);
        LIMIT_H = 1'b1;
        step();
        LIMIT_H = 1'b0;
        chk("sweep_v_state", int'(STATE), 2);
        chk("sweep_v_out", int'({BTN0_H, ES_H, BTN0_V, ES_V}), 4'b0011);
        repeat (5) step();
        LIMIT_V = 1'b1;
        step();
        LIMIT_V = 1'b0;
        chk("sample_state", int'(STATE), 3);
        chk("sample_out", int'({btnv()!=0, ES_H, ES_V, BUSY}), 4'b0001);
    endtask

    // One sample -> move -> settle transaction predicted from the rules
    task automatic run_txn(input int l, input int r, input int t,
                           input int b, input int abort_at);
        int  dh, dv, ax, exp_hi, expv, ms, n, m, bd;
        bit  rh, rv, ccw, lim;
        dh = l - r;
        dv = t - b;
        rh = (dh > DEADBAND) || (-dh > DEADBAND);
        rv = (dv > DEADBAND) || (-dv > DEADBAND);
        ax = -1;
        if (rh && rv) ax = (last_srv == 0) ? 1 : 0;
        else if (rh)  ax = 0;
        else if (rv)  ax = 1;
        exp_hi = 0;
        expv   = 0;
        ms     = 0;
        if (ax >= 0) begin
            ccw = (ax == 0) ? (dh > 0) : (dv > 0);
            lim = (ax == 0) ? LIMIT_H : LIMIT_V;
            last_srv = ax;
            if (!(ccw && lim)) begin
                exp_hi = (abort_at > 0 && ccw) ? abort_at : STEP_CYC;
                if (ax == 0) expv = ccw ? 8 : 4;
                else         expv = ccw ? 2 : 1;
                ms = (ax == 0) ? 4 : 5;
            end
        end
        wait_state(3, "pre_sample");
        LDR_L = DW'(l);
        LDR_R = DW'(r);
        LDR_T = DW'(t);
        LDR_B = DW'(b);
        VALID = 1'b1;
        step();
        VALID = 1'b0;
        n  = 0;
        bd = 0;
        while (btnv() != 0 && n < STEP_CYC + 5) begin
            if (btnv() != expv || int'(STATE) != ms || ES_H || ES_V) bd++;
            n++;
            if (n == abort_at) begin
                if (ax == 0) LIMIT_H = 1'b1;
                else         LIMIT_V = 1'b1;
            end
            step();
        end
        chk("hi_cycles", n, exp_hi);
        chk("btn_vec", bd, 0);
        m = 0;
        while (int'(STATE) == 6 && btnv() == 0 && m < SETTLE_CYC + 5) begin
            m++;
            step();
        end
        chk("settle_cycles", m, SETTLE_CYC);
        chk("back_sample", int'(STATE), 3);
        if (abort_at > 0) begin
            LIMIT_H = 1'b0;
            LIMIT_V = 1'b0;
        end
    endtask

    initial begin
        int a, c, d, e, f, g;
        RST_N   = 1'b0;
        START   = 1'b0;
        STOP    = 1'b0;
        VALID   = 1'b0;
        LIMIT_H = 1'b0;
        LIMIT_V = 1'b0;
        LDR_L   = '0;
        LDR_R   = '0;
        LDR_T   = '0;
        LDR_B   = '0;
        last_srv = 1;
        #23;
        chk("rst_outs", int'({btnv()!=0, ES_H, ES_V, BUSY}), 0);
        chk("rst_state", int'(STATE), 0);
        repeat (3) @(posedge CLK);
        #1 RST_N = 1'b1;
        repeat (3) step();
        chk("idle_hold", int'(STATE), 0);

        do_sweep();
        run_txn(900, 100, 900, 100, 0);
        run_txn(900, 100, 500, 500, 0);
        run_txn(500, 500, 500, 508, 0);
        run_txn(500, 500, 500, 509, 0);
        for (int i = 0; i < 4; i++) run_txn(100, 900, 3000, 200, 0);
        run_txn(2000, 1000, 700, 700, 30);
        LIMIT_H = 1'b1;
        run_txn(2000, 1000, 700, 700, 0);
        LIMIT_H = 1'b0;

        for (int i = 0; i < 20; i++) begin
            a = $urandom_range(600, 3400);
            c = $urandom_range(600, 3400);
            d = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 24) - 12
                                            : $urandom_range(0, 1000) - 500;
            e = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 24) - 12
                                            : $urandom_range(0, 1000) - 500;
            f = $urandom_range(0, 3);
            g = $urandom_range(0, 3);
            LIMIT_H = (f == 0);
            LIMIT_V = (g == 0);
            run_txn(a, a - d, c, c - e, 0);
        end
        LIMIT_H = 1'b0;
        LIMIT_V = 1'b0;

        wait_state(3, "stop_pre");
        LDR_L = 12'd2000;
        LDR_R = 12'd2000;
        LDR_T = 12'd100;
        LDR_B = 12'd900;
        VALID = 1'b1;
        step();
        VALID = 1'b0;
        repeat (49) step();
        chk("stop_moving", btnv(), 1);
        STOP  = 1'b1;
        START = 1'b1;
        step();
        STOP  = 1'b0;
        START = 1'b0;
        chk("stop_state", int'(STATE), 0);
        chk("stop_outs", int'({btnv()!=0, ES_H, ES_V, BUSY}), 0);
        repeat (5) step();
        chk("stop_idle", int'(STATE), 0);
        do_sweep();

        LDR_L = 12'd3000;
        LDR_R = 12'd100;
        LDR_T = 12'd500;
        LDR_B = 12'd500;
        VALID = 1'b1;
        step();
        VALID = 1'b0;
        repeat (20) step();
        #2 RST_N = 1'b0;
        #1;
        chk("async_outs", int'({btnv()!=0, ES_H, ES_V, BUSY}), 0);
        chk("async_state", int'(STATE), 0);
        last_srv = 1;
        repeat (2) @(posedge CLK);
        #1 RST_N = 1'b1;
        repeat (10) step();
        chk("post_rst_idle", int'(STATE), 0);
        do_sweep();
        run_txn(100, 900, 100, 900, 0);
        run_txn(100, 900, 100, 900, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
